// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, turned into word accesses on the A/WD/WE/RD memory port.
// Sub-word stores are read-modify-write. Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  output logic                     mem_WE,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);

  generate
    if (DATA_WIDTH != 32) begin : g_width_check
      $error("load_store_unit: only DATA_WIDTH = 32 is supported");
    end
  endgenerate

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic                  we_p0;
  logic                  err_p0;
  logic [2:0]            funct3_p0;
  logic [1:0]            lane_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [DATA_WIDTH-1:0] word_p1;
  logic                  req_illegal;
  logic                  req_misaligned;
  logic                  req_err;
  logic                  accept;

  // Little-endian lane extraction with sign or zero extension.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [2:0]            f3,
    input logic [1:0]            lane,
    input logic [DATA_WIDTH-1:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [2:0]            f3,
    input logic [1:0]            lane,
    input logic [DATA_WIDTH-1:0] w,
    input logic [DATA_WIDTH-1:0] wd
  );
    logic [DATA_WIDTH-1:0] r;
    r = w;
    if (f3[1:0] == 2'b00) begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (f3[1:0] == 2'b01) begin
      if (lane[1]) r[31:16] = wd[15:0];
      else         r[15:0]  = wd[15:0];
    end else begin
      r = wd;
    end
    return r;
  endfunction

  always_comb begin
    if (req_we) req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else        req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  // Misaligned halves and words are silently forced aligned by lane selection.
  assign req_misaligned = 1'b0;
`endif

  assign req_err = req_illegal || req_misaligned;
  assign accept  = (state == S_IDLE) && req_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                                 state_nxt = S_RESP;
          else if (req_we && req_funct3[1:0] == 2'b10) state_nxt = S_WRITE;
          else                                         state_nxt = S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_nxt = S_RD_DATA;
      S_RD_DATA: state_nxt = we_p0 ? S_WRITE : S_RESP;
      S_WRITE:   state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: request capture; stage p1: read word capture and store merge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      we_p0  <= 1'b0;
      err_p0 <= 1'b0;
      mem_A  <= '0;
      mem_WD <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_p0  <= req_we;
        err_p0 <= req_err;
        if (!req_err) begin
          mem_A <= {2'b00, req_addr[ADDRESS_WIDTH-1:2]};
          if (req_we) mem_WD <= req_wdata;
        end
      end
      if (state == S_RD_DATA && we_p0) begin
        mem_WD <= store_merge(funct3_p0, lane_p0, mem_RD, wdata_p0);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      funct3_p0 <= req_funct3;
      lane_p0   <= req_addr[1:0];
      wdata_p0  <= req_wdata;
    end
    if (state == S_RD_DATA) word_p1 <= mem_RD;
  end

  assign req_ready  = (state == S_IDLE);
  assign mem_WE     = (state == S_WRITE);
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid && err_p0;
  assign resp_rdata = (resp_valid && !we_p0 && !err_p0) ?
                      load_extract(funct3_p0, lane_p0, word_p1) : '0;

endmodule
